// File: rtl/seq_mac.sv
// Sequential shift-add multiplier/accumulator: one iteration per cycle, WIDTH iterations.
// Optional macro SEQ_MAC_SIGNED_EN enables signed ops (op[0]=1); otherwise op[0] is ignored.
module seq_mac #(
  parameter int WIDTH = 32
) (
  input  logic               clka,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               acc_clr,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] dataOut
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               accum;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [2*WIDTH-1:0] result;

  // prod_nxt already includes the current iteration, so the final edge can load it directly
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

`ifdef SEQ_MAC_SIGNED_EN
  logic signed_op;
  logic neg;
  assign signed_op = op[0];
  // Negating the most negative value wraps back to itself, which is its correct unsigned magnitude
  assign mag_a  = (signed_op && dataA[WIDTH-1]) ? -dataA : dataA;
  assign mag_b  = (signed_op && dataB[WIDTH-1]) ? -dataB : dataB;
  assign result = neg ? -prod_nxt : prod_nxt;
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign mag_a  = dataA;
  assign mag_b  = dataB;
  assign result = prod_nxt;
`endif

  always_ff @(posedge clka) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      dataOut <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      cnt     <= '0;
      accum   <= 1'b0;
`ifdef SEQ_MAC_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (acc_clr)
            dataOut <= '0;
          if (start) begin
            state  <= RUN;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            prod   <= '0;
            cnt    <= CW'(WIDTH - 1);
            accum  <= op[1];
`ifdef SEQ_MAC_SIGNED_EN
            neg    <= signed_op & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
`endif
          end
        end
        RUN: begin
          busy   <= 1'b1;
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) begin
            state   <= DONE;
            dataOut <= accum ? (dataOut + result) : result;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mac.sv
// Self-checking bench for seq_mac (WIDTH=32): directed corner cases plus random ops
// against a plain-arithmetic reference model of the accumulator.
module tb_seq_mac;
  localparam int W = 32;

  logic          clka = 1'b0;
  logic          rst, start, acc_clr;
  logic [1:0]    op;
  logic [W-1:0]  dataA, dataB;
  logic          busy, done;
  logic [2*W-1:0] dataOut;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] acc_m;

  seq_mac #(.WIDTH(W)) dut (
    .clka(clka), .rst(rst), .start(start), .op(op), .acc_clr(acc_clr),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done), .dataOut(dataOut)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
`ifdef SEQ_MAC_SIGNED_EN
    if (o[0]) return 64'(longint'($signed(a)) * longint'($signed(b)));
`endif
    return {32'b0, a} * {32'b0, b};
  endfunction

  // noise[0]: pulse start (A=B=9) mid-run; noise[1]: pulse acc_clr mid-run. Both must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic clr, input logic [1:0] noise);
    int done_at, busy_n, done_n, both;
    @(negedge clka);
    start = 1'b1; op = o; dataA = a; dataB = b; acc_clr = clr;
    if (clr) acc_m = '0;
    acc_m = o[1] ? acc_m + ref_prod(o, a, b) : ref_prod(o, a, b);
    @(negedge clka);
    start = 1'b0; acc_clr = 1'b0;
    dataA = $urandom; dataB = $urandom; op = 2'($urandom);
    done_at = 0; busy_n = 0; done_n = 0; both = 0;
    for (int k = 1; k <= W + 3; k++) begin
      if (k == 10) begin
        if (noise[0]) begin start = 1'b1; dataA = 9; dataB = 9; end
        if (noise[1]) acc_clr = 1'b1;
      end
      if (k == 11) begin start = 1'b0; acc_clr = 1'b0; end
      @(negedge clka);
      if (busy) busy_n++;
      if (done) done_n++;
      if (busy && done) both++;
      if (done && done_at == 0) done_at = k;
    end
    chk("done_latency", 128'(done_at), 128'(W + 1));
    chk("done_pulses", 128'(done_n), 128'd1);
    chk("busy_cycles", 128'(busy_n), 128'(W));
    chk("busy_done_overlap", 128'(both), 128'd0);
    chk("result", 128'(dataOut), 128'(acc_m));
  endtask

  initial begin
    logic [63:0] held;
    int busy_seen, done_seen;
    rst = 1'b1; start = 1'b0; acc_clr = 1'b0; op = 2'b00; dataA = '0; dataB = '0;
    repeat (3) @(negedge clka);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_dataOut", 128'(dataOut), 128'd0);
    rst = 1'b0;
    acc_m = '0;

    // full-scale unsigned
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00);
    chk("mulu_max", 128'(dataOut), 128'(64'hFFFF_FFFE_0000_0001));

    // signed vs. op[0]-ignored
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 2'b00);
`ifdef SEQ_MAC_SIGNED_EN
    chk("mul_neg3x7", 128'(dataOut), 128'(64'hFFFF_FFFF_FFFF_FFEB));
`else
    chk("mul_neg3x7", 128'(dataOut), 128'(64'h0000_0006_FFFF_FFEB));
`endif

    // clear-with-start, then accumulate
    run_op(2'b10, 32'd2, 32'd3, 1'b1, 2'b00);
    chk("madd_clr_first", 128'(dataOut), 128'd6);
    run_op(2'b10, 32'd4, 32'd5, 1'b0, 2'b00);
    chk("madd_second", 128'(dataOut), 128'd26);

    // build all-ones accumulator, then wrap
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00);
    run_op(2'b10, 32'd2, 32'hFFFF_FFFF, 1'b0, 2'b00);
    chk("acc_all_ones", 128'(dataOut), 128'(64'hFFFF_FFFF_FFFF_FFFF));
    run_op(2'b10, 32'd1, 32'd1, 1'b0, 2'b00);
    chk("acc_wrap", 128'(dataOut), 128'd0);

    // ignored start mid-run, and ignored acc_clr mid-run
    run_op(2'b00, 32'd3, 32'd4, 1'b0, 2'b01);
    chk("ignored_start", 128'(dataOut), 128'd12);
    run_op(2'b10, 32'd10, 32'd10, 1'b0, 2'b10);
    chk("ignored_clr", 128'(dataOut), 128'd112);

    // IDLE stability, then acc_clr alone
    held = dataOut;
    repeat (20) @(negedge clka);
    chk("idle_hold", 128'(dataOut), 128'(held));
    acc_clr = 1'b1;
    @(negedge clka);
    acc_clr = 1'b0;
    acc_m = '0;
    chk("acc_clr_idle", 128'(dataOut), 128'd0);

    // rst on the 10th RUN cycle
    run_op(2'b00, 32'd7, 32'd6, 1'b0, 2'b00);
    @(negedge clka);
    start = 1'b1; op = 2'b00; dataA = 5; dataB = 5;
    @(negedge clka);
    start = 1'b0;
    repeat (9) @(negedge clka);
    rst = 1'b1;
    @(negedge clka);
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_dataOut", 128'(dataOut), 128'd0);
    busy_seen = 0; done_seen = 0;
    for (int k = 0; k < W + 5; k++) begin
      @(negedge clka);
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    chk("abort_no_done", 128'(done_seen), 128'd0);
    chk("abort_no_busy", 128'(busy_seen), 128'd0);
    chk("abort_dataOut_hold", 128'(dataOut), 128'd0);
    acc_m = '0;

    // random ops
    for (int i = 0; i < 24; i++) begin
      run_op(2'($urandom), $urandom, $urandom, ($urandom_range(0, 3) == 0),
             2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
